// File: rtl/wt_ptr_full_gen.sv
// Write-domain pointer, full/almost-full and push-on-full error logic
// for the async FIFO; syncs the read Gray pointer into wt_clk_fsm.
module wt_ptr_full_gen #(
  parameter int ADDR_W         = 4,
  parameter int ALMOST_FULL_TH = 2
) (
  input  logic              wt_clk_fsm,
  input  logic              rst_n_in_wt_fsm,
  input  logic              push_in,
  input  logic              wt_en_in,
  input  logic [ADDR_W:0]   rd_gray_ptr_in,
  input  logic              err_clr_in,
  output logic              mem_we_out,
  output logic [ADDR_W-1:0] wt_addr_out,
  output logic [ADDR_W:0]   wt_gray_ptr_out,
  output logic              full_out,
  output logic              almost_full_out,
  output logic              push_on_full_error_out,
  output logic              err_sticky_out,
  output logic [ADDR_W:0]   wt_count_out
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int PW    = ADDR_W + 1;

  logic [PW-1:0] wbin;
  logic [PW-1:0] wgray;
  logic [PW-1:0] sync1;
  logic [PW-1:0] sync2;
  logic [PW-1:0] rd_bin_sync;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] full_cmp;
  logic [PW-1:0] count;
  logic [PW:0]   free;
  logic          full;
  logic          err_pulse;
  logic          err_sticky;
  logic          accept;
  logic          push_full;

  // Reset gating keeps the strobe quiet while the pointer is held at 0
  assign accept    = push_in & wt_en_in & ~full & rst_n_in_wt_fsm;
  assign push_full = push_in & full;

  assign wbin_next  = wbin + {{ADDR_W{1'b0}}, accept};
  assign wgray_next = wbin_next ^ (wbin_next >> 1);
  assign full_cmp   = {~sync2[PW-1:PW-2], sync2[PW-3:0]};

  always_comb begin
    rd_bin_sync = '0;
    for (int i = 0; i < PW; i++) begin
      rd_bin_sync[i] = ^(sync2 >> i);
    end
  end

  assign count = wbin - rd_bin_sync;
  assign free  = (PW+1)'(DEPTH) - {1'b0, count};

  always_ff @(posedge wt_clk_fsm or negedge rst_n_in_wt_fsm) begin
    if (!rst_n_in_wt_fsm) begin
      wbin       <= '0;
      wgray      <= '0;
      sync1      <= '0;
      sync2      <= '0;
      full       <= 1'b0;
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      wbin       <= wbin_next;
      wgray      <= wgray_next;
      sync1      <= rd_gray_ptr_in;
      sync2      <= sync1;
      full       <= (wgray_next == full_cmp);
      err_pulse  <= push_full;
      err_sticky <= push_full | (err_sticky & ~err_clr_in);
    end
  end

  assign mem_we_out             = accept;
  assign wt_addr_out            = wbin[ADDR_W-1:0];
  assign wt_gray_ptr_out        = wgray;
  assign full_out               = full;
  assign almost_full_out        = free <= (PW+1)'(ALMOST_FULL_TH);
  assign push_on_full_error_out = err_pulse;
  assign err_sticky_out         = err_sticky;
  assign wt_count_out           = count;

endmodule

// File: tb/tb_wt_ptr_full_gen.sv
// Directed bench for wt_ptr_full_gen (ADDR_W=4, ALMOST_FULL_TH=2).
// Inputs change after negedge; registered outputs are sampled #1 after posedge.
module tb_wt_ptr_full_gen;

  logic       clk;
  logic       rst_n;
  logic       push;
  logic       en;
  logic [4:0] rd_gray;
  logic       clr;
  logic       we;
  logic [3:0] addr;
  logic [4:0] gray;
  logic       full;
  logic       afull;
  logic       perr;
  logic       sticky;
  logic [4:0] cnt;

  int checks = 0;
  int errors = 0;

  wt_ptr_full_gen #(.ADDR_W(4), .ALMOST_FULL_TH(2)) dut (
    .wt_clk_fsm             (clk),
    .rst_n_in_wt_fsm        (rst_n),
    .push_in                (push),
    .wt_en_in               (en),
    .rd_gray_ptr_in         (rd_gray),
    .err_clr_in             (clr),
    .mem_we_out             (we),
    .wt_addr_out            (addr),
    .wt_gray_ptr_out        (gray),
    .full_out               (full),
    .almost_full_out        (afull),
    .push_on_full_error_out (perr),
    .err_sticky_out         (sticky),
    .wt_count_out           (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] g(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic test_reset;
    rst_n = 1'b0; push = 1'b0; en = 1'b1; rd_gray = '0; clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({we, addr, gray, full, afull, perr, sticky, cnt} !== 19'd0) begin
      errors++;
      $display("FAIL reset_init got=%h exp=0",
               {we, addr, gray, full, afull, perr, sticky, cnt});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      push = 1'b1;
    end
    @(posedge clk);
    #1;
    checks++;
    if (addr !== 4'd3) begin
      errors++;
      $display("FAIL reset_mid_pre addr got=%0d exp=3", addr);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({we, addr, gray, full, afull, perr, sticky, cnt} !== 19'd0) begin
      errors++;
      $display("FAIL reset_mid got=%h exp=0",
               {we, addr, gray, full, afull, perr, sticky, cnt});
    end
    @(posedge clk);
    #1;
    checks++;
    if (we !== 1'b0 || addr !== 4'd0) begin
      errors++;
      $display("FAIL reset_mid_hold we=%b addr=%0d exp we=0 addr=0", we, addr);
    end
    @(negedge clk);
    push = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_fill;
    rd_gray = '0;
    en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      push = 1'b1;
      #1;
      checks++;
      if (we !== 1'b1 || addr !== 4'(i) || full !== 1'b0) begin
        errors++;
        $display("FAIL fill_%0d we=%b addr=%0d full=%b exp we=1 addr=%0d full=0",
                 i, we, addr, full, i);
      end
      checks++;
      if (cnt !== 5'(i) || afull !== (i >= 14)) begin
        errors++;
        $display("FAIL almost_full_%0d cnt=%0d afull=%b exp cnt=%0d afull=%b",
                 i, cnt, afull, i, (i >= 14));
      end
    end
    @(posedge clk);
    #1;
    push = 1'b0;
    checks++;
    if (full !== 1'b1 || gray !== 5'b11000 || cnt !== 5'd16) begin
      errors++;
      $display("FAIL fill_full full=%b gray=%b cnt=%0d exp 1 11000 16",
               full, gray, cnt);
    end
  endtask

  task automatic test_push_on_full;
    @(negedge clk);
    push = 1'b1;
    #1;
    checks++;
    if (we !== 1'b0 || addr !== 4'd0) begin
      errors++;
      $display("FAIL pof_comb we=%b addr=%0d exp we=0 addr=0", we, addr);
    end
    @(posedge clk);
    #1;
    push = 1'b0;
    checks++;
    if (perr !== 1'b1 || sticky !== 1'b1 || addr !== 4'd0 || full !== 1'b1) begin
      errors++;
      $display("FAIL pof_pulse perr=%b sticky=%b addr=%0d full=%b exp 1 1 0 1",
               perr, sticky, addr, full);
    end
    @(posedge clk);
    #1;
    checks++;
    if (perr !== 1'b0 || sticky !== 1'b1) begin
      errors++;
      $display("FAIL pof_after perr=%b sticky=%b exp 0 1", perr, sticky);
    end
  endtask

  task automatic test_err_clear;
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (sticky !== 1'b0) begin
      errors++;
      $display("FAIL err_clr sticky=%b exp 0", sticky);
    end
    @(negedge clk);
    clr = 1'b1;
    push = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    push = 1'b0;
    checks++;
    if (sticky !== 1'b1 || perr !== 1'b1) begin
      errors++;
      $display("FAIL err_clr_set_wins sticky=%b perr=%b exp 1 1", sticky, perr);
    end
  endtask

  task automatic test_full_release;
    @(negedge clk);
    rd_gray = 5'b00001;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (full !== (k < 3)) begin
        errors++;
        $display("FAIL release_edge%0d full=%b exp %b", k, full, (k < 3));
      end
    end
    checks++;
    if (cnt !== 5'd15) begin
      errors++;
      $display("FAIL release_cnt cnt=%0d exp 15", cnt);
    end
    @(negedge clk);
    push = 1'b1;
    #1;
    checks++;
    if (we !== 1'b1 || addr !== 4'd0) begin
      errors++;
      $display("FAIL release_push we=%b addr=%0d exp we=1 addr=0", we, addr);
    end
    @(posedge clk);
    #1;
    push = 1'b0;
    checks++;
    if (full !== 1'b1 || cnt !== 5'd16) begin
      errors++;
      $display("FAIL refill full=%b cnt=%0d exp 1 16", full, cnt);
    end
  endtask

  task automatic test_wrap;
    logic [4:0] prev;
    int n;
    @(negedge clk);
    rst_n = 1'b0;
    rd_gray = '0;
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      rd_gray = g(5'((n >= 4) ? n - 4 : 0));
      push = 1'b1;
      en = 1'b1;
      #1;
      checks++;
      if (we !== 1'b1 || addr !== 4'(n % 16) || full !== 1'b0) begin
        errors++;
        $display("FAIL wrap_w%0d we=%b addr=%0d full=%b exp we=1 addr=%0d full=0",
                 n, we, addr, full, n % 16);
      end
      prev = gray;
      @(posedge clk);
      #1;
      checks++;
      if (gray !== g(5'((n + 1) % 32)) || $countones(prev ^ gray) != 1) begin
        errors++;
        $display("FAIL wrap_gray%0d got=%b prev=%b exp=%b",
                 n, gray, prev, g(5'((n + 1) % 32)));
      end
      n++;
    end
    push = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (cnt !== 5'd5 || afull !== 1'b0 || full !== 1'b0) begin
      errors++;
      $display("FAIL wrap_settle cnt=%0d afull=%b full=%b exp 5 0 0",
               cnt, afull, full);
    end
  endtask

  task automatic test_enable_gating;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      en = 1'b0;
      push = 1'b1;
      #1;
      checks++;
      if (we !== 1'b0) begin
        errors++;
        $display("FAIL gate_we%0d we=%b exp 0", i, we);
      end
      @(posedge clk);
      #1;
      checks++;
      if (addr !== 4'd8 || gray !== 5'b01100 || perr !== 1'b0) begin
        errors++;
        $display("FAIL gate_hold%0d addr=%0d gray=%b perr=%b exp 8 01100 0",
                 i, addr, gray, perr);
      end
    end
    push = 1'b0;
    en = 1'b1;
  endtask

  initial begin
    test_reset;
    test_reset_mid;
    test_fill;
    test_push_on_full;
    test_err_clear;
    test_full_release;
    test_wrap;
    test_enable_gating;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
